// File: rtl/complex_accum_sat_pkg.sv
// Shared fixed-point definitions for the complex accumulator: FSM encodings
// and the Q-format range helpers used when narrowing the accumulator.
package complex_accum_sat_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    function automatic int q_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int q_min(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/complex_accum_sat_narrow.sv
// fx_narrow: reduces a guard-extended sum to WIDTH bits and flags out-of-range values.
// Wraps by default; COMPLEX_ACCUM_SATURATE_EN clamps to the Q-format limits instead.
module fx_narrow
    import complex_accum_sat_pkg::*;
#(
    parameter int AW    = 8,
    parameter int WIDTH = 6
)
(
    input  logic signed [AW-1:0]    sum,
    output logic signed [WIDTH-1:0] result,
    output logic                    ovf
);

    localparam logic signed [AW-1:0] MAX_AW = AW'(q_max(WIDTH));
    localparam logic signed [AW-1:0] MIN_AW = AW'(q_min(WIDTH));

    always_comb begin
        ovf    = (sum > MAX_AW) || (sum < MIN_AW);
        result = sum[WIDTH-1:0];
`ifdef COMPLEX_ACCUM_SATURATE_EN
        if (ovf) begin
            result = sum[AW-1] ? MIN_AW[WIDTH-1:0] : MAX_AW[WIDTH-1:0];
        end
`endif
    end

endmodule

// File: rtl/complex_accum_sat.sv
// Streaming complex accumulator: sums NTAPS samples per frame and holds the
// narrowed result until taken. COMPLEX_ACCUM_SATURATE_EN selects clamping over wrap.
module complex_accum_sat
    import complex_accum_sat_pkg::*;
#(
    parameter int QI    = 3,
    parameter int QF    = 3,
    parameter int NTAPS = 3,
    parameter int GUARD = $clog2(NTAPS)
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [QI+QF-1:0]  in_re,
    input  logic signed [QI+QF-1:0]  in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [QI+QF-1:0]  out_re,
    output logic signed [QI+QF-1:0]  out_im,
    output logic                     overflow
);

    localparam int WIDTH = QI + QF;
    localparam int AW    = WIDTH + GUARD;
    localparam int CW    = $clog2(NTAPS);
    localparam logic [CW-1:0] LAST_CNT = CW'(NTAPS - 1);

    state_t                  state_reg, state_next;
    logic signed [AW-1:0]    acc_re_reg, acc_im_reg;
    logic signed [AW-1:0]    sum_re, sum_im;
    logic [CW-1:0]           cnt_reg;
    logic signed [WIDTH-1:0] nar_re, nar_im;
    logic signed [WIDTH-1:0] out_re_reg, out_im_reg;
    logic                    overflow_reg;
    logic                    ovf_re, ovf_im;
    logic                    accept, last;

    assign accept = in_valid && in_ready;
    assign last   = accept && (cnt_reg == LAST_CNT);
    // The sum includes the incoming sample so the final result is narrowed in the accept cycle.
    assign sum_re = acc_re_reg + {{GUARD{in_re[WIDTH-1]}}, in_re};
    assign sum_im = acc_im_reg + {{GUARD{in_im[WIDTH-1]}}, in_im};

    fx_narrow #(.AW(AW), .WIDTH(WIDTH)) u_narrow_re (
        .sum    (sum_re),
        .result (nar_re),
        .ovf    (ovf_re)
    );

    fx_narrow #(.AW(AW), .WIDTH(WIDTH)) u_narrow_im (
        .sum    (sum_im),
        .result (nar_im),
        .ovf    (ovf_im)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_ACCUM;
            acc_re_reg   <= '0;
            acc_im_reg   <= '0;
            cnt_reg      <= '0;
            out_re_reg   <= '0;
            out_im_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (clr || last) begin
                acc_re_reg <= '0;
                acc_im_reg <= '0;
                cnt_reg    <= '0;
            end else if (accept) begin
                acc_re_reg <= sum_re;
                acc_im_reg <= sum_im;
                cnt_reg    <= cnt_reg + CW'(1);
            end
            if (last && !clr) begin
                out_re_reg   <= nar_re;
                out_im_reg   <= nar_im;
                overflow_reg <= ovf_re | ovf_im;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ACCUM: if (last && !clr)        state_next = ST_HOLD;
            ST_HOLD:  if (clr || out_ready)    state_next = ST_ACCUM;
            default:                           state_next = ST_ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == ST_ACCUM);
        out_valid = (state_reg == ST_HOLD);
        out_re    = out_re_reg;
        out_im    = out_im_reg;
        overflow  = overflow_reg;
    end

endmodule
